i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter QTR, default 63: system-clock cycles per SCL quarter-period; SCL period = 4*QTR clk (99.2 kHz at 25 MHz); legal range 2..1023.
REQ-002 clk  input  1  system clock; all logic is posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-clk command strobe; honored only when busy=0.
REQ-005 rw  input  1  0 = register write, 1 = register read; sampled with start.
REQ-006 slave_id  input  7  target 7-bit address; sampled with start.
REQ-007 addr  input  8  register address byte; sampled with start.
REQ-008 len  input  4  data byte count 0..15; sampled with start.
REQ-009 wdata  input  8  write byte; sampled at the start of each write data byte.
REQ-010 wdata_req  output  1  one-clk pulse after wdata is captured; the user then presents the next byte.
REQ-011 rdata  output  8  last received byte; held until the next byte completes.
REQ-012 rdata_valid  output  1  one-clk pulse when rdata is updated.
REQ-013 busy  output  1  high from the clk after an accepted start until the clk done pulses.
REQ-014 done  output  1  one-clk pulse when the transaction ends, after STOP.
REQ-015 nack_err  output  1  set on any slave NACK; cleared on the next accepted start.
REQ-016 scl_out  output  1  SCL drive (0 = pull low, 1 = release); no clock stretching.
REQ-017 sda_out  output  1  SDA drive (0 = pull low, 1 = release).
REQ-018 sda_in  input  1  SDA pin value; the block synchronizes it with a 2-flop synchronizer before use.

Function
REQ-019 Quarter counter: counts 0..QTR-1 and advances the phase q0..q3 on wrap.
 - q0: SCL low; SDA updates here.
 - q1: SCL rises.
 - q2: SCL high; sda_in sampled here.
 - q3: SCL falls.
REQ-020 FSM states: IDLE, START, TXBIT, TXACK, RXBIT, RXACK, RSTART, STOP.
REQ-021 IDLE: scl_out=1, sda_out=1, counter held at 0; an accepted start enters START at the next clk.
REQ-022 START: sda_out falls while SCL is high (one quarter), then SCL goes low; enters TXBIT with byte {slave_id,0}.
REQ-023 TXBIT: shifts 8 bits MSB first, then goes to TXACK.
REQ-024 TXACK: releases SDA and samples ACK at q2.
 - 1 = NACK: set nack_err and go to STOP.
REQ-025 Write sequence (rw=0): ID+W, addr, then len data bytes, then STOP.
 - len=0 = address-only write.
REQ-026 Read sequence (rw=1, len>0): ID+W, addr, RSTART, ID+R, then len RXBIT bytes.
 - Master ACKs (drives 0) every byte except the last, which gets NACK (1).
 - Then STOP.
REQ-027 rw=1 with len=0 behaves exactly as a write with len=0.
REQ-028 RSTART: releases SDA with SCL low, raises SCL, pulls SDA low while SCL is high, then pulls SCL low.
REQ-029 RXBIT: samples 8 bits MSB first at q2.
 - rdata and rdata_valid update at the end of bit 8, before RXACK.
REQ-030 STOP: SDA low while SCL low, SCL rises, then SDA rises while SCL is high.
 - One further quarter of bus-free time follows, then done pulses and the FSM returns to IDLE.
REQ-031 SDA never changes while SCL is high, except for the START, RSTART and STOP edges.
REQ-032 A start received while busy=1 is ignored and has no side effects.
REQ-033 Byte counter decrements per data byte; len is never exceeded, and a 4-bit value of 15 completes without wrap.
REQ-034 wdata_req pulses once per write data byte: exactly len pulses, or fewer if aborted by NACK.

Reset
REQ-035 Reset values:
 - FSM=IDLE; scl_out=1, sda_out=1.
 - busy, done, wdata_req, rdata_valid, nack_err = 0; rdata=0.
 - Counters and synchronizer = 0.
REQ-036 Reset asserted mid-transaction releases both lines immediately.
 - No STOP is generated, and no done pulse is generated.

Verification
REQ-037 QTR=4, write id=0x24, addr=0x10, len=2, data 0xA5,0x3C, slave ACKs all:
 - Bus shows bytes 0x48, 0x10, 0xA5, 0x3C.
 - 2 wdata_req pulses, done=1, nack_err=0.
REQ-038 Read id=0x24, addr=0x05, len=3, slave returns 0x11,0x22,0x33:
 - Bus shows bytes 0x48, 0x05, RSTART, 0x49.
 - rdata_valid ×3 with values 0x11, 0x22, 0x33; master ACK, ACK, NACK; then STOP and done.
REQ-039 No device at id=0x50 (SDA stays high):
 - NACK on the first byte sets nack_err=1.
 - STOP follows immediately, done pulses, and there are zero wdata_req pulses.
REQ-040 start re-pulsed while busy, plus len=0 write: second start ignored; len=0 write gives ID+W, addr, STOP only.
REQ-041 rst_n asserted during bit 4 of the addr byte:
 - scl_out=1 and sda_out=1 within the same clk edge, busy=0, no done.
 - A new transaction after release completes normally.
REQ-042 Protocol checker on every test: SDA is stable while SCL is high except at START/RSTART/STOP edges, and the SCL period is 4*QTR clk ±0.

Source files
------------

// File: rtl/i2c_master_if.sv
// Command, status and pin bundle between an I2C register-access master and its user/pad logic.
interface i2c_master_if;
  logic       start;
  logic       rw;
  logic [6:0] slave_id;
  logic [7:0] addr;
  logic [3:0] len;
  logic [7:0] wdata;
  logic       wdata_req;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic       done;
  logic       nack_err;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;

  modport master (
    input  start, rw, slave_id, addr, len, wdata, sda_in,
    output wdata_req, rdata, rdata_valid, busy, done, nack_err, scl_out, sda_out
  );

  modport slave (
    output start, rw, slave_id, addr, len, wdata, sda_in,
    input  wdata_req, rdata, rdata_valid, busy, done, nack_err, scl_out, sda_out
  );
endinterface

// File: rtl/i2c_master.sv
// I2C register-access master: START, ID+W, addr, then write data or RSTART/ID+R/read data, STOP.
// SCL period 4*QTR clk, all outputs registered; sda_in passes a 2-flop synchronizer.
module i2c_master #(
  parameter int QTR = 63
) (
  input logic          clk,
  input logic          rst_n,
  i2c_master_if.master bus_if
);
  typedef enum logic [2:0] {IDLE, START, TXBIT, TXACK, RXBIT, RXACK, RSTART, STOP} state_e;
  typedef enum logic [1:0] {STG_IDW, STG_ADDR, STG_DATA, STG_IDR} stage_e;

  localparam logic [9:0] QTR_LAST = 10'(QTR - 1);

  state_e     state_q;
  stage_e     stage_q;
  logic [9:0] cnt_q;
  logic [1:0] ph_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic [3:0] bytes_q;
  logic       rw_q;
  logic [6:0] id_q;
  logic [7:0] addr_q;
  logic       ack_q;
  logic [1:0] sync_q;
  logic       scl_q, sda_q, busy_q, done_q, wreq_q, rvld_q, nerr_q;
  logic [7:0] rdata_q;
  logic       tick, sda_s;

  assign tick  = (cnt_q == QTR_LAST);
  assign sda_s = sync_q[1];

  // Each bit slot is q0..q3: SDA moves entering q0, SCL rises entering q1 and falls entering q3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;     stage_q <= STG_IDW;
      cnt_q   <= '0;       ph_q    <= '0;
      bit_q   <= '0;       shift_q <= '0;
      bytes_q <= '0;       rw_q    <= 1'b0;
      id_q    <= '0;       addr_q  <= '0;
      ack_q   <= 1'b0;     sync_q  <= '0;
      scl_q   <= 1'b1;     sda_q   <= 1'b1;
      busy_q  <= 1'b0;     done_q  <= 1'b0;
      wreq_q  <= 1'b0;     rvld_q  <= 1'b0;
      nerr_q  <= 1'b0;     rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      wreq_q <= 1'b0;
      rvld_q <= 1'b0;
      sync_q <= {sync_q[0], bus_if.sda_in};
      if (state_q == IDLE) begin
        cnt_q <= '0;
        ph_q  <= '0;
        scl_q <= 1'b1;
        sda_q <= 1'b1;
        if (bus_if.start) begin
          rw_q    <= bus_if.rw;
          id_q    <= bus_if.slave_id;
          addr_q  <= bus_if.addr;
          bytes_q <= bus_if.len;
          nerr_q  <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= START;
          // START occupies only the second half of a slot so SCL keeps its period afterwards.
          ph_q    <= 2'd2;
          sda_q   <= 1'b0;
        end
      end else begin
        cnt_q <= tick ? '0 : cnt_q + 10'd1;
        if (tick) begin
          ph_q <= ph_q + 2'd1;
          case (ph_q)
            2'd0: scl_q <= 1'b1;
            2'd1: begin
              if (state_q == RSTART) sda_q <= 1'b0;
              else if (state_q == STOP) sda_q <= 1'b1;
            end
            2'd2: begin
              if (state_q != STOP) scl_q <= 1'b0;
              if (state_q == TXACK) begin
                ack_q <= sda_s;
                if (sda_s) nerr_q <= 1'b1;
              end
              if (state_q == RXBIT) begin
                shift_q <= {shift_q[6:0], sda_s};
                if (bit_q == 3'd0) begin
                  rdata_q <= {shift_q[6:0], sda_s};
                  rvld_q  <= 1'b1;
                end
              end
            end
            default: begin
              case (state_q)
                START: begin
                  state_q <= TXBIT;  stage_q <= STG_IDW;
                  sda_q   <= id_q[6]; shift_q <= {id_q[5:0], 2'b00}; bit_q <= 3'd7;
                end
                RSTART: begin
                  state_q <= TXBIT;  stage_q <= STG_IDR;
                  sda_q   <= id_q[6]; shift_q <= {id_q[5:0], 2'b10}; bit_q <= 3'd7;
                end
                TXBIT: begin
                  if (bit_q == 3'd0) begin
                    state_q <= TXACK;
                    sda_q   <= 1'b1;
                  end else begin
                    sda_q   <= shift_q[7];
                    shift_q <= {shift_q[6:0], 1'b0};
                    bit_q   <= bit_q - 3'd1;
                  end
                end
                TXACK: begin
                  if (ack_q) begin
                    state_q <= STOP; sda_q <= 1'b0;
                  end else if (stage_q == STG_IDW) begin
                    state_q <= TXBIT;  stage_q <= STG_ADDR;
                    sda_q   <= addr_q[7]; shift_q <= {addr_q[6:0], 1'b0}; bit_q <= 3'd7;
                  end else if (stage_q == STG_IDR) begin
                    state_q <= RXBIT; sda_q <= 1'b1; bit_q <= 3'd7;
                  end else if (stage_q == STG_ADDR && rw_q && bytes_q != 4'd0) begin
                    state_q <= RSTART; sda_q <= 1'b1;
                  end else if (bytes_q == 4'd0) begin
                    state_q <= STOP; sda_q <= 1'b0;
                  end else begin
                    state_q <= TXBIT;  stage_q <= STG_DATA;
                    sda_q   <= bus_if.wdata[7];
                    shift_q <= {bus_if.wdata[6:0], 1'b0};
                    bit_q   <= 3'd7;
                    bytes_q <= bytes_q - 4'd1;
                    wreq_q  <= 1'b1;
                  end
                end
                RXBIT: begin
                  if (bit_q == 3'd0) begin
                    state_q <= RXACK;
                    sda_q   <= (bytes_q == 4'd1);
                  end else begin
                    sda_q <= 1'b1;
                    bit_q <= bit_q - 3'd1;
                  end
                end
                RXACK: begin
                  bytes_q <= bytes_q - 4'd1;
                  if (bytes_q == 4'd1) begin
                    state_q <= STOP; sda_q <= 1'b0;
                  end else begin
                    state_q <= RXBIT; sda_q <= 1'b1; bit_q <= 3'd7;
                  end
                end
                STOP: begin
                  state_q <= IDLE;
                  ph_q    <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
                default: ;
              endcase
            end
          endcase
        end
      end
    end
  end

  assign bus_if.scl_out     = scl_q;
  assign bus_if.sda_out     = sda_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;
  assign bus_if.wdata_req   = wreq_q;
  assign bus_if.rdata       = rdata_q;
  assign bus_if.rdata_valid = rvld_q;
  assign bus_if.nack_err    = nerr_q;
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: protocol-level slave/monitor, token-list reference model, table + random transactions.
module tb_i2c_master;
  localparam int QTR    = 4;
  localparam int TOK_S  = 256;
  localparam int TOK_SR = 257;
  localparam int TOK_P  = 258;
  localparam int TOK_AK = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  i2c_master_if bus();
  i2c_master #(.QTR(QTR)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Written only by the stimulus process.
  logic [7:0] wb [16];
  logic [7:0] rb [16];
  int         wbase = 0, rbase = 0;
  logic [6:0] dev_id = 7'h24;
  bit         dev_en = 1'b1;
  int         exp_q [$];

  // Written only by the monitor process.
  int         wreq_cnt = 0, done_cnt = 0, rd_cnt = 0, proto_err = 0, per_err = 0;
  int         log_q [$];
  int         got_q [$];
  bit         pscl = 1'b1, psda = 1'b1, sl_drv = 1'b1, in_txn = 1'b0;
  bit         first_byte = 1'b0, addressed = 1'b0, pend_rd = 1'b0, rd_mode = 1'b0, mack = 1'b0;
  int         bitn = 0, last_r = -1, last_f = -1;
  logic [7:0] sh = '0, rd_cur = '0;

  assign bus.wdata  = wb[4'(wreq_cnt - wbase)];
  assign bus.sda_in = bus.sda_out & sl_drv;

  // Open-drain slave at dev_id plus bus decoder: logs S/Sr/P, master-sent bytes and master ACK bits.
  always @(negedge clk) begin
    bit s_scl, s_sda;
    s_scl = bus.scl_out;
    s_sda = bus.sda_in;
    if (bus.done) done_cnt++;
    if (bus.wdata_req) wreq_cnt++;
    if (bus.rdata_valid) got_q.push_back(int'(bus.rdata));
    if (!rst_n || !bus.busy) begin
      last_r = -1; last_f = -1;
    end else begin
      if (s_scl && !pscl) begin
        if (last_r >= 0 && cyc - last_r != 4 * QTR) per_err++;
        last_r = cyc;
      end
      if (!s_scl && pscl) begin
        if (last_f >= 0 && cyc - last_f != 4 * QTR) per_err++;
        last_f = cyc;
      end
    end
    if (!rst_n) begin
      sl_drv = 1'b1; bitn = 0; in_txn = 1'b0; addressed = 1'b0; pend_rd = 1'b0; rd_mode = 1'b0;
    end else if (s_scl && pscl && psda && !s_sda) begin
      if (bitn > 1) proto_err++;
      log_q.push_back(in_txn ? TOK_SR : TOK_S);
      in_txn = 1'b1; bitn = 0; first_byte = 1'b1; addressed = 1'b0; pend_rd = 1'b0; rd_mode = 1'b0;
      sl_drv = 1'b1;
    end else if (s_scl && pscl && !psda && s_sda) begin
      if (bitn > 1) proto_err++;
      log_q.push_back(TOK_P);
      in_txn = 1'b0; bitn = 0; addressed = 1'b0; rd_mode = 1'b0; sl_drv = 1'b1;
    end else if (s_scl && !pscl) begin
      if (bitn < 8) sh = {sh[6:0], s_sda};
      else if (rd_mode && bitn == 8) begin
        mack = s_sda;
        log_q.push_back(TOK_AK + int'(s_sda));
      end
      bitn++;
    end else if (!s_scl && pscl) begin
      if (bitn == 8) begin
        if (rd_mode) sl_drv = 1'b1;
        else begin
          log_q.push_back(int'(sh));
          if (first_byte) begin
            addressed  = dev_en && (sh[7:1] == dev_id);
            pend_rd    = addressed && sh[0];
            first_byte = 1'b0;
          end
          sl_drv = !addressed;
        end
      end else if (bitn == 9) begin
        bitn = 0;
        sl_drv = 1'b1;
        if (pend_rd) begin rd_mode = 1'b1; pend_rd = 1'b0; mack = 1'b0; end
        if (rd_mode && !mack) begin
          rd_cur = rb[4'(rd_cnt - rbase)];
          rd_cnt++;
          sl_drv = rd_cur[7];
        end else rd_mode = 1'b0;
      end else if (rd_mode && bitn >= 1 && bitn <= 7) begin
        sl_drv = rd_cur[3'(7 - bitn)];
      end
    end
    pscl = s_scl;
    psda = bus.sda_in;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the bus traffic a register access must produce, as an ordered token list.
  task automatic build_exp(input bit rw, input logic [6:0] id, input logic [7:0] a,
                           input int len, input bit present);
    exp_q = {};
    exp_q.push_back(TOK_S);
    exp_q.push_back(int'({id, 1'b0}));
    if (present) begin
      exp_q.push_back(int'(a));
      if (len > 0 && !rw) for (int i = 0; i < len; i++) exp_q.push_back(int'(wb[i]));
      if (len > 0 && rw) begin
        exp_q.push_back(TOK_SR);
        exp_q.push_back(int'({id, 1'b1}));
        for (int i = 0; i < len; i++) exp_q.push_back(TOK_AK + ((i == len - 1) ? 1 : 0));
      end
    end
    exp_q.push_back(TOK_P);
  endtask

  task automatic fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 16; i++) begin
      wb[i] = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : 8'(int'(b2) + i * 7);
      rb[i] = wb[i];
    end
  endtask

  task automatic run_txn(input string tag, input bit rw, input logic [6:0] id, input logic [7:0] a,
                         input int len, input bit present, input int exp_nack, input int exp_wreq,
                         input int exp_rv, input bit repulse);
    int t0, lb, gb, db, k, act;
    t0 = cyc;
    while (bus.busy && cyc - t0 < 5000) @(negedge clk);
    wbase = wreq_cnt; rbase = rd_cnt; dev_id = id; dev_en = present;
    lb = log_q.size(); gb = got_q.size(); db = done_cnt;
    build_exp(rw, id, a, len, present);
    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw; bus.slave_id = id; bus.addr = a; bus.len = 4'(len);
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc; k = 0;
    while (done_cnt == db && cyc - t0 < 8000) begin
      @(negedge clk);
      k++;
      if (repulse && k == 20) begin
        bus.start = 1'b1; bus.rw = ~rw; bus.slave_id = ~id; bus.addr = ~a; bus.len = 4'd9;
      end
      if (repulse && k == 21) bus.start = 1'b0;
    end
    check({tag, " done"}, done_cnt - db, 1);
    repeat (40) @(negedge clk);
    check({tag, " single done"}, done_cnt - db, 1);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " nack_err"}, int'(bus.nack_err), exp_nack);
    check({tag, " wdata_req"}, wreq_cnt - wbase, exp_wreq);
    check({tag, " bus tokens"}, log_q.size() - lb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (lb + i < log_q.size()) ? log_q[lb + i] : -1;
      check($sformatf("%s token%0d", tag, i), act, exp_q[i]);
    end
    check({tag, " rdata count"}, got_q.size() - gb, exp_rv);
    for (int i = 0; i < exp_rv && gb + i < got_q.size(); i++)
      check($sformatf("%s rdata%0d", tag, i), got_q[gb + i], int'(rb[i]));
    check({tag, " protocol"}, proto_err, 0);
    check({tag, " scl period"}, per_err, 0);
  endtask

  typedef struct {
    bit         rw;
    logic [6:0] id;
    logic [7:0] a;
    int         len;
    bit         present;
    logic [7:0] b0, b1, b2;
    int         exp_nack;
    int         exp_wreq;
    int         exp_rv;
  } vec_t;

  initial begin
    vec_t vt [8];
    int   t0, db, lb, len;
    bit   rw, present;
    logic [6:0] id;
    logic [7:0] a;

    vt[0] = '{1'b0, 7'h24, 8'h10,  2, 1'b1, 8'hA5, 8'h3C, 8'h00, 0,  2,  0};
    vt[1] = '{1'b1, 7'h24, 8'h05,  3, 1'b1, 8'h11, 8'h22, 8'h33, 0,  0,  3};
    vt[2] = '{1'b0, 7'h50, 8'h10,  2, 1'b0, 8'h01, 8'h02, 8'h03, 1,  0,  0};
    vt[3] = '{1'b0, 7'h24, 8'h33,  0, 1'b1, 8'h00, 8'h00, 8'h00, 0,  0,  0};
    vt[4] = '{1'b1, 7'h24, 8'h44,  0, 1'b1, 8'h00, 8'h00, 8'h00, 0,  0,  0};
    vt[5] = '{1'b0, 7'h24, 8'h7E, 15, 1'b1, 8'hF0, 8'h0F, 8'h81, 0, 15,  0};
    vt[6] = '{1'b1, 7'h24, 8'h01, 15, 1'b1, 8'hC3, 8'h5A, 8'h7F, 0,  0, 15};
    vt[7] = '{1'b1, 7'h50, 8'h20,  4, 1'b0, 8'h00, 8'h00, 8'h00, 1,  0,  0};

    bus.start = 1'b0; bus.rw = 1'b0; bus.slave_id = '0; bus.addr = '0; bus.len = '0;
    fill(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("reset scl", int'(bus.scl_out), 1);
    check("reset sda", int'(bus.sda_out), 1);
    check("reset status", int'({bus.busy, bus.done, bus.nack_err, bus.wdata_req, bus.rdata_valid}), 0);
    check("reset rdata", int'(bus.rdata), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      fill(vt[v].b0, vt[v].b1, vt[v].b2);
      run_txn($sformatf("vec%0d", v), vt[v].rw, vt[v].id, vt[v].a, vt[v].len, vt[v].present,
              vt[v].exp_nack, vt[v].exp_wreq, vt[v].exp_rv, 1'b0);
    end

    fill(8'h00, 8'h00, 8'h00);
    run_txn("repulse", 1'b0, 7'h24, 8'h33, 0, 1'b1, 0, 0, 0, 1'b1);

    // Reset during bit 4 of the address byte.
    fill(8'hA5, 8'h3C, 8'h00);
    wbase = wreq_cnt; rbase = rd_cnt; dev_id = 7'h24; dev_en = 1'b1;
    db = done_cnt; lb = log_q.size();
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.slave_id = 7'h24; bus.addr = 8'h10; bus.len = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    while (!(log_q.size() == lb + 2 && bitn == 4) && cyc - t0 < 2000) @(negedge clk);
    check("rst reached addr bit4", int'(log_q.size() == lb + 2 && bitn == 4), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst scl released", int'(bus.scl_out), 1);
    check("rst sda released", int'(bus.sda_out), 1);
    check("rst busy", int'(bus.busy), 0);
    repeat (10) @(negedge clk);
    check("rst no done", done_cnt - db, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn("after rst", 1'b0, 7'h24, 8'h10, 2, 1'b1, 0, 2, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rw      = 1'($urandom_range(0, 1));
      id      = 7'($urandom_range(0, 127));
      a       = 8'($urandom_range(0, 255));
      len     = $urandom_range(0, 6);
      present = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 16; i++) begin
        wb[i] = 8'($urandom_range(0, 255));
        rb[i] = 8'($urandom_range(0, 255));
      end
      run_txn($sformatf("rand%0d", r), rw, id, a, len, present, present ? 0 : 1,
              (present && !rw) ? len : 0, (present && rw) ? len : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
